// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous input in i_clk cycles.
// Results leave on a valid/ready interface; a missing edge raises a sticky timeout.

`timescale 1ns/1ps

module clock_period_meter #(
    parameter int CNT_W       = 16,
    parameter int MAX_COUNT   = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } stateT;

    stateT r_state;
    stateT w_nextState;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sPrev;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_highLat;
    logic             w_atMax;

    logic             r_valid;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_overrun;
    logic             r_timeout;

    logic w_clearCount;
    logic w_startCount;
    logic w_countEn;
    logic w_latchHigh;
    logic w_load;
    logic w_timeoutSet;
    logic w_timeoutClr;

    // Both edges see the same synchronizer delay, so it cancels out of every measurement.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync  <= '0;
            r_sPrev <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_sPrev <= w_s;
        end
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_s & ~r_sPrev;
    assign w_fall  = ~w_s & r_sPrev;
    assign w_atMax = (r_count == MAX_CNT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_clearCount = 1'b0;
        w_startCount = 1'b0;
        w_countEn    = 1'b0;
        w_latchHigh  = 1'b0;
        w_load       = 1'b0;
        w_timeoutSet = 1'b0;
        w_timeoutClr = 1'b0;
        case (r_state)
            IDLE: begin
                // Waiting for a low level avoids a false rise when i_sig is high at start.
                w_clearCount = 1'b1;
                if (!w_s) begin
                    w_nextState = ARM;
                end
            end
            ARM: begin
                if (w_rise) begin
                    w_startCount = 1'b1;
                    w_timeoutClr = 1'b1;
                    w_nextState  = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_latchHigh = 1'b1;
                    w_countEn   = 1'b1;
                    w_nextState = LOW;
                end else if (w_atMax) begin
                    w_timeoutSet = 1'b1;
                    w_nextState  = IDLE;
                end else begin
                    w_countEn = 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_load       = 1'b1;
                    w_startCount = 1'b1;
                    w_nextState  = HIGH;
                end else if (w_atMax) begin
                    w_timeoutSet = 1'b1;
                    w_nextState  = IDLE;
                end else begin
                    w_countEn = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Counter starts at 1 on a rise so that it equals the interval length at the next edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (w_clearCount) begin
            r_count <= '0;
        end else if (w_startCount) begin
            r_count <= ONE;
        end else if (w_countEn && !w_atMax) begin
            r_count <= r_count + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_highLat <= '0;
        end else if (w_latchHigh) begin
            r_highLat <= r_count;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeoutSet) begin
            r_timeout <= 1'b1;
        end else if (w_timeoutClr) begin
            r_timeout <= 1'b0;
        end
    end

    // A load in the same cycle as an accept replaces the result without flagging an overrun.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_period  <= r_count;
            r_high    <= r_highLat;
            r_overrun <= r_valid & ~i_ready;
        end else if (r_valid && i_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_period  = r_period;
    assign o_high    = r_high;
    assign o_overrun = r_overrun;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a background generator drives i_sig,
// the main sequence checks results against hand-computed cycle counts.

`timescale 1ns/1ps

module tb_clock_period_meter;

    logic        i_clk;
    logic        i_rst;
    logic        i_sig;
    logic        i_ready;
    logic        o_valid;
    logic [15:0] o_period;
    logic [15:0] o_high;
    logic        o_overrun;
    logic        o_timeout;

    int   checks = 0;
    int   errors = 0;

    int   genHigh  = 3;
    int   genLow   = 3;
    int   genEpoch = 0;
    bit   genOn    = 1'b0;
    logic genLevel = 1'b1;

    int   cyc;
    int   validCount;

    clock_period_meter #(
        .CNT_W      (16),
        .MAX_COUNT  (20),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_sig    (i_sig),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_period (o_period),
        .o_high   (o_high),
        .o_overrun(o_overrun),
        .o_timeout(o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Waveform generator: each new epoch restarts the pattern at the first high cycle.
    initial begin
        int phase;
        int lastEpoch;
        phase     = 0;
        lastEpoch = 0;
        i_sig     = 1'b1;
        forever begin
            @(negedge i_clk);
            if (genEpoch != lastEpoch) begin
                lastEpoch = genEpoch;
                phase     = 0;
            end
            if (genOn) begin
                i_sig = (phase < genHigh);
                phase = (phase + 1 >= genHigh + genLow) ? 0 : phase + 1;
            end else begin
                i_sig = genLevel;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int high, input int low, input bit on, input logic level);
        genHigh  = high;
        genLow   = low;
        genLevel = level;
        genEpoch = genEpoch + 1;
        genOn    = on;
    endtask

    task automatic waitValid(input int maxCycles, output int cycles);
        cycles = 0;
        do begin
            @(negedge i_clk);
            cycles++;
        end while (!o_valid && cycles < maxCycles);
        checkOutput("validSeen", o_valid, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"},   o_valid,   0);
        checkOutput({tag, "Period"},  o_period,  0);
        checkOutput({tag, "High"},    o_high,    0);
        checkOutput({tag, "Overrun"}, o_overrun, 0);
        checkOutput({tag, "Timeout"}, o_timeout, 0);
    endtask

    initial begin
        i_rst   = 1'b0;
        i_ready = 1'b1;
        applyStimulus(3, 3, 1'b0, 1'b1);
        repeat (3) @(negedge i_clk);
        checkAllZero("reset");

        // Release with i_sig held high: nothing may be measured.
        i_rst = 1'b1;
        validCount = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_valid) validCount++;
        end
        checkOutput("noRiseWhileHigh", validCount, 0);
        checkOutput("noTimeoutInIdle", o_timeout, 0);

        // Period 6, high 3, always ready.
        applyStimulus(3, 3, 1'b1, 1'b1);
        waitValid(60, cyc);
        checkOutput("p6Period", o_period, 6);
        checkOutput("p6High", o_high, 3);
        checkOutput("p6Overrun", o_overrun, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checkOutput("p6PulseOneCycle", o_valid, 0);
            waitValid(20, cyc);
            checkOutput("p6Spacing", cyc + 1, 6);
            checkOutput("p6PeriodRepeat", o_period, 6);
            checkOutput("p6HighRepeat", o_high, 3);
            checkOutput("p6OverrunRepeat", o_overrun, 0);
        end

        // Stuck low forces a timeout; then high 5 / low 11 with a stalled consumer.
        applyStimulus(3, 3, 1'b0, 1'b0);
        repeat (40) @(negedge i_clk);
        checkOutput("timeoutStuckLow", o_timeout, 1);
        checkOutput("noValidStuckLow", o_valid, 0);
        i_ready = 1'b0;
        applyStimulus(5, 11, 1'b1, 1'b0);
        waitValid(80, cyc);
        checkOutput("asymPeriod", o_period, 16);
        checkOutput("asymHigh", o_high, 5);
        checkOutput("asymOverrunFirst", o_overrun, 0);
        checkOutput("asymTimeoutCleared", o_timeout, 0);
        repeat (16) @(negedge i_clk);
        checkOutput("overrunValid", o_valid, 1);
        checkOutput("overrunFlag", o_overrun, 1);
        checkOutput("overrunPeriod", o_period, 16);
        checkOutput("overrunHigh", o_high, 5);
        i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("acceptDropsValid", o_valid, 0);
        checkOutput("acceptClearsOverrun", o_overrun, 0);
        waitValid(40, cyc);
        checkOutput("nextAfterAccept", cyc, 15);
        checkOutput("nextOverrun", o_overrun, 0);
        checkOutput("nextPeriod", o_period, 16);

        // Stuck high right after a rise: timeout lands 20 cycles later.
        applyStimulus(5, 11, 1'b0, 1'b1);
        repeat (19) @(negedge i_clk);
        checkOutput("noTimeoutBeforeMax", o_timeout, 0);
        @(negedge i_clk);
        checkOutput("timeoutAtMax", o_timeout, 1);
        checkOutput("timeoutNoValid", o_valid, 0);
        applyStimulus(5, 11, 1'b1, 1'b1);
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (o_timeout && cyc < 60);
        checkOutput("timeoutCleared", o_timeout, 0);
        waitValid(40, cyc);
        checkOutput("resultAfterClear", cyc, 16);
        checkOutput("clearPeriod", o_period, 16);
        checkOutput("clearHigh", o_high, 5);
        checkOutput("clearOverrun", o_overrun, 0);

        // Reset mid-HIGH with a result pending.
        @(negedge i_clk);
        checkOutput("validDroppedBeforeRst", o_valid, 0);
        i_ready = 1'b0;
        waitValid(40, cyc);
        i_rst = 1'b0;
        #1;
        checkAllZero("midRst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        waitValid(60, cyc);
        checkOutput("firstAfterReset", cyc, 30);
        checkOutput("rstPeriod", o_period, 16);
        checkOutput("rstHigh", o_high, 5);
        checkOutput("rstOverrun", o_overrun, 0);

        // Overrun, then accept in the same cycle a new result loads.
        repeat (16) @(negedge i_clk);
        checkOutput("preSameValid", o_valid, 1);
        checkOutput("preSameOverrun", o_overrun, 1);
        repeat (15) @(negedge i_clk);
        i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("sameCycleValid", o_valid, 1);
        checkOutput("sameCycleOverrun", o_overrun, 0);
        checkOutput("sameCyclePeriod", o_period, 16);
        checkOutput("sameCycleHigh", o_high, 5);
        @(negedge i_clk);
        checkOutput("sameCycleAccepted", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures an incoming slow or divided clock (e.g. a divider's o_clk, or an external pin) in i_clk cycles, reporting period and high time.
- Complements the divider: the divider generates the slow clock, this block checks and measures it.
- Used for clock self-test and frequency readback by the CPU debug path.
- Results go out on a valid/ready interface; a missing or stuck input is flagged as a timeout.

Parameters:
- CNT_W, 16: width of the cycle counter and result fields.
- MAX_COUNT, 65535: timeout limit in i_clk cycles. Must be at most 2^CNT_W-1 and at least 2.
- SYNC_STAGES, 2: synchronizer flops on i_sig. Minimum 2.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-low.
- i_sig  input  1  signal to measure, asynchronous to i_clk.
- i_ready  input  1  consumer accepts the current result.
- o_valid  output  1  result available; held until accepted.
- o_period  output  CNT_W  rise-to-rise period in i_clk cycles.
- o_high  output  CNT_W  rise-to-fall high time in i_clk cycles.
- o_overrun  output  1  the presented result overwrote an unaccepted one.
- o_timeout  output  1  no required edge within MAX_COUNT cycles (level).

Behaviour:
- Reset values (all flops cleared):
  - synchronizer chain 0, edge-history flop 0, counter 0, state IDLE.
  - o_valid 0, o_period 0, o_high 0, o_overrun 0, o_timeout 0.
- Reset is asynchronous at any time, including mid-measurement or mid-handshake. The pending result is discarded.
- Synchronizer and edge detect:
  - s = last synchronizer stage; rise = s & ~s_prev; fall = ~s & s_prev.
  - Edge detection latency is SYNC_STAGES+1 cycles. This latency is identical for both edges, so measurements are unaffected by it.
- States:
  - IDLE: wait for s==0, then go to ARM. This prevents a false rise when i_sig is already high at reset release.
  - ARM: on rise, counter<=1 and go to HIGH.
  - HIGH: counter increments each cycle.
    - On fall: high_lat<=counter, go to LOW.
  - LOW: counter increments each cycle.
    - On rise: load o_period<=counter and o_high<=high_lat.
    - Set o_valid, counter<=1, go to HIGH. Back-to-back measurements continue without re-arming.
- Counting rule: for an input with period P and high time H, measured in i_clk cycles, the block reports o_period=P and o_high=H.
- Timeout:
  - In HIGH or LOW, if counter==MAX_COUNT and the expected edge is not detected that cycle: set o_timeout=1, go to IDLE.
  - The counter saturates and never wraps.
  - o_timeout stays 1 until the next rise is detected in ARM, which clears it.
  - A timeout does not affect a result already presented.
- Handshake:
  - o_period, o_high and o_overrun are stable while o_valid=1 && i_ready=0.
  - When o_valid && i_ready, o_valid goes 0 on the next cycle, unless a new result loads that same cycle.
  - New result while o_valid=1 && i_ready=0: overwrite the data, keep o_valid=1, set o_overrun=1.
  - New result in the same cycle as an accept: load the new data, o_valid stays 1, o_overrun=0.
  - o_overrun clears when its result is accepted.
  - o_valid is asserted for every completed rise-to-rise interval.
- Arithmetic: unsigned, CNT_W bits. The minimum legal input period is 2 cycles high plus 2 cycles low; shorter pulses may be missed.

Test Plan:
- Reset release with i_sig held high -> no rise is detected until a low has been seen; the first o_valid follows the first real low-to-high edge.
- i_sig period 6, high 3 (divider with DIVIDER=2), i_ready=1 -> o_valid pulses for one cycle every 6 cycles with o_period=6, o_high=3, o_overrun=0.
- Asymmetric i_sig, high 5, low 11, i_ready=0 for two periods and then 1 -> o_period=16, o_high=5, o_overrun=1 at accept; the next result has o_overrun=0.
- MAX_COUNT=20, i_sig stuck high after a rise -> o_timeout=1 twenty cycles after the rise, state IDLE; later edges (low then rise) clear o_timeout, and a valid result follows one period later.
- Assert i_rst mid-HIGH while o_valid=1 -> all outputs 0 immediately; after release, no result appears until ARM sees a rise.
- New result in the same cycle as o_valid&&i_ready -> o_valid stays 1 with the new values, o_overrun=0.
